// File: rtl/sequence_frame_transmitter.sv
// Transmit side of the byte-stream sync protocol: sync header AB CD EF 24
// followed by PAYLOAD_LEN bytes pulled from a valid/ready source.
module sequence_frame_transmitter #(
    parameter int unsigned PAYLOAD_LEN = 4,
    parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] SYNC_B0 = 8'hAB;
    localparam logic [7:0] SYNC_B1 = 8'hCD;
    localparam logic [7:0] SYNC_B2 = 8'hEF;
    localparam logic [7:0] SYNC_B3 = 8'h24;
    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC2,
        SYNC3,
        SYNC4,
        PAYLOAD
    } state_t;

    state_t     state, state_n;
    logic [7:0] count, count_n;
    logic [7:0] data_n;
    logic       data_valid_n;
    logic       done_n;
    logic       xfer;

    assign in_ready = (state == PAYLOAD);
    assign busy     = (state != IDLE);
    assign xfer     = in_ready && in_valid;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            count      <= 8'd0;
            data       <= IDLE_BYTE;
            data_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            data       <= data_n;
            data_valid <= data_valid_n;
            done       <= done_n;
        end
    end

    // Every cycle without a frame byte drives IDLE_BYTE with valid low.
    always_comb begin
        state_n      = state;
        count_n      = count;
        data_n       = IDLE_BYTE;
        data_valid_n = 1'b0;
        done_n       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    data_n       = SYNC_B0;
                    data_valid_n = 1'b1;
                    state_n      = SYNC2;
                end
            end
            SYNC2: begin
                data_n       = SYNC_B1;
                data_valid_n = 1'b1;
                state_n      = SYNC3;
            end
            SYNC3: begin
                data_n       = SYNC_B2;
                data_valid_n = 1'b1;
                state_n      = SYNC4;
            end
            SYNC4: begin
                data_n       = SYNC_B3;
                data_valid_n = 1'b1;
                count_n      = 8'd0;
                state_n      = PAYLOAD;
            end
            PAYLOAD: begin
                if (xfer) begin
                    data_n       = in_data;
                    data_valid_n = 1'b1;
                    if (count == LAST_IDX) begin
                        count_n = 8'd0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        count_n = count + 8'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                count_n = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_sequence_frame_transmitter.sv
// Directed bench for sequence_frame_transmitter: per-cycle expected tables
// for data, data_valid, done, busy and in_ready.
module tb_sequence_frame_transmitter;

    logic       clk;
    logic       nrst;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data;
    logic       data_valid;
    logic       busy;
    logic       done;

    int n_chk;
    int n_fail;

    logic [7:0] ed[$];
    logic [7:0] pay[$];
    string st_s, iv_s, ev_s, dn_s, eb_s, er_s;

    sequence_frame_transmitter #(
        .PAYLOAD_LEN(4),
        .IDLE_BYTE(8'h00)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .start(start),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data(data),
        .data_valid(data_valid),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_at(input string s, input int i);
        return (s[i] == "1");
    endfunction

    // Drive one cycle per table entry; a handshake is taken from
    // in_ready/in_valid as they stand just before the active edge.
    task automatic run(input string name);
        int  idx;
        logic hs;
        idx = 0;
        for (int i = 0; i < ed.size(); i++) begin
            @(negedge clk);
            start    = bit_at(st_s, i);
            in_valid = bit_at(iv_s, i);
            in_data  = (idx < pay.size()) ? pay[idx] : 8'hEE;
            hs       = in_ready && in_valid;
            @(posedge clk);
            #1;
            if (hs) idx++;
            chk($sformatf("%s[%0d] data", name, i), 32'(data), 32'(ed[i]));
            chk($sformatf("%s[%0d] valid", name, i),
                32'(data_valid), 32'(bit_at(ev_s, i)));
            chk($sformatf("%s[%0d] done", name, i),
                32'(done), 32'(bit_at(dn_s, i)));
            chk($sformatf("%s[%0d] busy", name, i),
                32'(busy), 32'(bit_at(eb_s, i)));
            chk($sformatf("%s[%0d] in_ready", name, i),
                32'(in_ready), 32'(bit_at(er_s, i)));
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic load_basic();
        pay  = {8'h11, 8'h22, 8'h33, 8'h44};
        ed   = {8'hAB, 8'hCD, 8'hEF, 8'h24,
                8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        st_s = "100000000";
        iv_s = "111111111";
        ev_s = "111111110";
        dn_s = "000000010";
        eb_s = "111111100";
        er_s = "000111100";
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        nrst     = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        chk("reset data", 32'(data), 32'h00);
        chk("reset valid", 32'(data_valid), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        nrst = 1'b1;

        load_basic();
        run("basic");

        pay  = {8'h11, 8'h22, 8'h33, 8'h44};
        ed   = {8'hAB, 8'hCD, 8'hEF, 8'h24, 8'h11, 8'h22,
                8'h00, 8'h00, 8'h00, 8'h33, 8'h44, 8'h00};
        st_s = "100000000000";
        iv_s = "111111000110";
        ev_s = "111111000110";
        dn_s = "000000000010";
        eb_s = "111111111100";
        er_s = "000111111100";
        run("gaps");

        load_basic();
        st_s = "101001000";
        run("start_busy");

        pay  = {8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88};
        ed   = {8'hAB, 8'hCD, 8'hEF, 8'h24, 8'h11, 8'h22, 8'h33, 8'h44,
                8'hAB, 8'hCD, 8'hEF, 8'h24, 8'h55, 8'h66, 8'h77, 8'h88,
                8'h00};
        st_s = "11111111111111110";
        iv_s = "11111111111111111";
        ev_s = "11111111111111110";
        dn_s = "00000001000000010";
        eb_s = "11111110111111100";
        er_s = "00011110000111100";
        run("b2b");

        pay  = {8'h11, 8'h22, 8'h33, 8'h44};
        ed   = {8'hAB, 8'hCD, 8'hEF};
        st_s = "100";
        iv_s = "111";
        ev_s = "111";
        dn_s = "000";
        eb_s = "111";
        er_s = "000";
        run("pre_rst");
        #2;
        nrst = 1'b0;
        #1;
        chk("midrst data", 32'(data), 32'h00);
        chk("midrst valid", 32'(data_valid), 32'h0);
        chk("midrst busy", 32'(busy), 32'h0);
        chk("midrst in_ready", 32'(in_ready), 32'h0);
        chk("midrst done", 32'(done), 32'h0);
        @(posedge clk);
        #1;
        chk("midrst hold done", 32'(done), 32'h0);
        chk("midrst hold data", 32'(data), 32'h00);
        @(negedge clk);
        nrst = 1'b1;
        load_basic();
        run("post_rst");

        pay  = {8'hAB};
        ed   = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        st_s = "00000";
        iv_s = "11111";
        ev_s = "00000";
        dn_s = "00000";
        eb_s = "00000";
        er_s = "00000";
        run("idle");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sequence_frame_transmitter.md
Name: sequence_frame_transmitter

Overview:
Transmit side of the byte-stream sync protocol. On a start request it emits the 4-byte sync sequence AB CD EF 24, then forwards exactly PAYLOAD_LEN payload bytes from an upstream valid/ready source. It drives the same one-byte-per-clock stream that the sync detector consumes. The block sits between the payload producer and the serial byte link.

Parameters:
PAYLOAD_LEN, 4, number of payload bytes per frame; legal range 1..255.
IDLE_BYTE, 8'h00, value driven on data whenever no byte is valid; must not equal 8'hAB.

Ports:
clk  input  1  system clock, rising edge.
nrst  input  1  asynchronous active-low reset.
start  input  1  frame request; sampled only in IDLE.
in_data  input  8  payload byte from upstream.
in_valid  input  1  in_data is valid.
in_ready  output  1  block accepts in_data this cycle.
data  output  8  transmitted byte stream (registered).
data_valid  output  1  data carries a frame byte (registered).
busy  output  1  frame in progress (state != IDLE).
done  output  1  one-cycle pulse, coincident with the last payload byte on data.

Behaviour:
- Clocking and reset: one clock, clk. Reset nrst is asynchronous and active-low.
- Reset values: state=IDLE, data=IDLE_BYTE, data_valid=0, done=0, payload count=0. Combinational outputs follow: busy=0, in_ready=0.
- State machine (binary encoded): IDLE, SYNC2, SYNC3, SYNC4, PAYLOAD.
- IDLE:
  - start=1 at an edge -> data<=8'hAB, data_valid<=1, state<=SYNC2.
  - Otherwise data<=IDLE_BYTE, data_valid<=0.
- SYNC2 -> data<=8'hCD, state<=SYNC3.
- SYNC3 -> data<=8'hEF, state<=SYNC4.
- SYNC4 -> data<=8'h24, count<=0, state<=PAYLOAD.
- Sync bytes go out on 4 consecutive cycles and are never stalled. Latency: start sampled at edge N -> AB visible after edge N, 24 visible after edge N+3.
- PAYLOAD:
  - in_ready=1 (combinational, state==PAYLOAD only).
  - Transfer occurs when in_valid && in_ready: data<=in_data, data_valid<=1, count<=count+1.
  - No transfer: data<=IDLE_BYTE, data_valid<=0. These gap cycles are allowed; frame state is held.
  - Transfer with count==PAYLOAD_LEN-1: state<=IDLE, done<=1 for exactly that cycle.
- Count: 8-bit; never exceeds PAYLOAD_LEN-1; no wrap.
- busy = (state != IDLE). busy is therefore already 0 during the cycle the last payload byte and done are on data.
- start while busy is ignored and has no effect on the frame. There is no queuing.
- Back-to-back frames: with start=1 in the cycle done is high, the next AB follows the last payload byte with no gap.
- in_ready=0 outside PAYLOAD. in_valid there is ignored and upstream data is not consumed.
- Payload is not escaped. A payload containing AB CD EF 24 is sent verbatim; framing above this block handles it.
- Reset mid-frame: immediate return to reset values. The partial frame is dropped; there is no done pulse.

Test Plan:
1. Basic frame, PAYLOAD_LEN=4: reset, pulse start, in_valid held 1 with bytes 11,22,33,44 -> data_valid high 8 consecutive cycles, data = AB,CD,EF,24,11,22,33,44. done=1 only on the 44 cycle; busy high 7 cycles; a downstream sync detector raises its flag the cycle after 24.
2. Payload gaps: in_valid low 3 cycles between 22 and 33 -> data_valid=0 and data=00 in those cycles; in_ready stays 1; frame completes with 33,44; done on 44.
3. Start while busy: pulse start again during SYNC3 and during PAYLOAD -> output identical to scenario 1; no second frame.
4. Back-to-back: start held high continuously -> sequence AB CD EF 24 p0..p3 AB CD EF 24 ... with no idle cycle; one done per frame.
5. Reset mid-frame: assert nrst=0 asynchronously after EF is on data -> data=00, data_valid=0, busy=0, in_ready=0 immediately; no done; next start produces a full fresh frame.
6. Idle behaviour: no start, in_valid=1 with data AB -> in_ready=0, data=00, data_valid=0 indefinitely.
